// File: rtl/adc_playback_tx.sv
// DDR sample serializer: unpacks 64-bit words (four 16-bit samples) from a small
// input FIFO or a built-in pattern source into 6-bit rising/falling edge data.
module adc_playback_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int RAMP_W     = 12
) (
  input  logic                          dco,
  input  logic                          rst_n,
  input  logic [1:0]                    mode,
  input  logic [63:0]                   wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [5:0]                    q_r,
  output logic [5:0]                    q_f,
  output logic                          frame,
  output logic                          underflow,
  input  logic                          clr_underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    MODE_FIFO  = 2'b00,
    MODE_RAMP  = 2'b01,
    MODE_CHECK = 2'b10,
    MODE_ZERO  = 2'b11
  } mode_e;

  // Sample layout is {2'b0, hi[5:0], 2'b0, lo[5:0]}; the spare bits are dropped here.
  function automatic logic [5:0] lo_of(input logic [15:0] smp);
    return smp[5:0];
  endfunction

  function automatic logic [5:0] hi_of(input logic [15:0] smp);
    return smp[13:8];
  endfunction

  function automatic logic [15:0] ramp_sample(input logic [RAMP_W-1:0] r);
    return {2'b00, r[11:6], 2'b00, r[5:0]};
  endfunction

  logic [63:0]       mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [LW-1:0]     level_r;

  logic [1:0]        idx_r;
  logic [63:0]       word_r;
  mode_e             mode_r;
  logic [RAMP_W-1:0] ramp_r;
  logic [5:0]        hi_hold_r;
  logic [5:0]        q_r_r;
  logic [5:0]        q_f_r;
  logic              frame_r;
  logic              underflow_r;

  logic              ready_s;
  logic              push_s;
  logic              pop_s;
  logic              starve_s;
  mode_e             cur_mode_s;
  logic [63:0]       cur_word_s;
  logic [15:0]       sample_s;

  assign ready_s    = (level_r < LW'(FIFO_DEPTH));
  assign push_s     = wr_valid && ready_s;
  assign wr_ready   = ready_s;
  assign fifo_level = level_r;
  assign q_r        = q_r_r;
  assign q_f        = q_f_r;
  assign frame      = frame_r;
  assign underflow  = underflow_r;

  // Word-boundary source selection: a fresh word/mode is taken only when idx is 0.
  always_comb begin
    pop_s      = 1'b0;
    starve_s   = 1'b0;
    cur_mode_s = mode_r;
    cur_word_s = word_r;
    if (idx_r == 2'd0) begin
      cur_mode_s = mode_e'(mode);
      if (cur_mode_s == MODE_FIFO) begin
        if (level_r != {LW{1'b0}}) begin
          pop_s      = 1'b1;
          cur_word_s = mem_r[rd_ptr_r];
        end else begin
          starve_s   = 1'b1;
          cur_word_s = 64'd0;
        end
      end else begin
        cur_word_s = 64'd0;
      end
    end else begin
      cur_mode_s = mode_r;
      cur_word_s = word_r;
    end
  end

  // Sample emitted this cycle for the active mode and position within the word.
  always_comb begin
    sample_s = 16'd0;
    case (cur_mode_s)
      MODE_FIFO: begin
        case (idx_r)
          2'd0:    sample_s = cur_word_s[63:48];
          2'd1:    sample_s = cur_word_s[47:32];
          2'd2:    sample_s = cur_word_s[31:16];
          2'd3:    sample_s = cur_word_s[15:0];
          default: sample_s = 16'd0;
        endcase
      end
      MODE_RAMP:  sample_s = ramp_sample(ramp_r);
      MODE_CHECK: sample_s = {2'b00, 6'h2A, 2'b00, 6'h15};
      MODE_ZERO:  sample_s = 16'd0;
      default:    sample_s = 16'd0;
    endcase
  end

  // Input FIFO storage and pointers; a word written now is readable from the next edge.
  always_ff @(posedge dco or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 64'd0;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + {{(LW-1){1'b0}}, 1'b1};
        2'b01:   level_r <= level_r - {{(LW-1){1'b0}}, 1'b1};
        default: level_r <= level_r;
      endcase
    end
  end

  // Serializer state and output registers; hi is delayed one cycle to pair with lo.
  always_ff @(posedge dco or negedge rst_n) begin
    if (!rst_n) begin
      idx_r       <= 2'd0;
      word_r      <= 64'd0;
      mode_r      <= MODE_FIFO;
      ramp_r      <= {RAMP_W{1'b0}};
      hi_hold_r   <= 6'd0;
      q_r_r       <= 6'd0;
      q_f_r       <= 6'd0;
      frame_r     <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      idx_r <= idx_r + 2'd1;
      if (idx_r == 2'd0) begin
        word_r <= cur_word_s;
        mode_r <= cur_mode_s;
      end
      if (cur_mode_s == MODE_RAMP) begin
        ramp_r <= ramp_r + {{(RAMP_W-1){1'b0}}, 1'b1};
      end
      q_f_r     <= lo_of(sample_s);
      hi_hold_r <= hi_of(sample_s);
      q_r_r     <= hi_hold_r;
      frame_r   <= (idx_r == 2'd0);
      // A fresh underflow outranks a clear on the same edge.
      if (starve_s) begin
        underflow_r <= 1'b1;
      end else if (clr_underflow) begin
        underflow_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_playback_tx.sv
// Scoreboard bench for adc_playback_tx: a behavioural model queues the expected
// outputs of every edge, which are popped and compared half a cycle later.
module tb_adc_playback_tx;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          dco = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic [63:0]   wr_data = 64'd0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [LW-1:0] fifo_level;
  logic [5:0]    q_r;
  logic [5:0]    q_f;
  logic          frame;
  logic          underflow;
  logic          clr_underflow = 1'b0;

  always #5 dco = ~dco;

  adc_playback_tx #(.FIFO_DEPTH(DEPTH), .RAMP_W(12)) dut (
    .dco(dco), .rst_n(rst_n), .mode(mode), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .fifo_level(fifo_level), .q_r(q_r), .q_f(q_f),
    .frame(frame), .underflow(underflow), .clr_underflow(clr_underflow)
  );

  typedef struct packed {
    logic [5:0]    q_f;
    logic [5:0]    q_r;
    logic          frame;
    logic          und;
    logic [LW-1:0] lvl;
    logic          rdy;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] m_fifo[$];
  int          m_idx;
  logic [63:0] m_word;
  logic [1:0]  m_mode;
  logic [11:0] m_ramp;
  logic [5:0]  m_hi;
  logic        m_und;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    m_idx  = 0;
    m_word = 64'd0;
    m_mode = 2'b00;
    m_ramp = 12'd0;
    m_hi   = 6'd0;
    m_und  = 1'b0;
  endtask

  // One clock: model the coming edge from current inputs, then compare at the next negedge.
  task automatic step(output bit accepted);
    exp_t        e;
    logic [15:0] smp;
    bit          set_und;
    accepted = wr_valid && (m_fifo.size() < DEPTH);
    set_und  = 1'b0;
    if (m_idx == 0) begin
      m_mode = mode;
      if (mode == 2'b00) begin
        if (m_fifo.size() > 0) m_word = m_fifo.pop_front();
        else begin
          m_word  = 64'd0;
          set_und = 1'b1;
        end
      end
    end
    case (m_mode)
      2'b00: smp = 16'(m_word >> (16 * (3 - m_idx)));
      2'b01: begin
        smp    = {2'b00, m_ramp[11:6], 2'b00, m_ramp[5:0]};
        m_ramp = m_ramp + 12'd1;
      end
      2'b10:   smp = {2'b00, 6'h2A, 2'b00, 6'h15};
      default: smp = 16'h0000;
    endcase
    if (accepted) m_fifo.push_back(wr_data);
    if (set_und) m_und = 1'b1;
    else if (clr_underflow) m_und = 1'b0;
    e.q_f   = smp[5:0];
    e.q_r   = m_hi;
    m_hi    = smp[13:8];
    e.frame = (m_idx == 0);
    e.und   = m_und;
    e.lvl   = LW'(m_fifo.size());
    e.rdy   = (m_fifo.size() < DEPTH);
    m_idx   = (m_idx + 1) % 4;
    exp_q.push_back(e);
    @(posedge dco);
    @(negedge dco);
    e = exp_q.pop_front();
    check_eq("q_f", q_f, e.q_f);
    check_eq("q_r", q_r, e.q_r);
    check_eq("frame", frame, e.frame);
    check_eq("underflow", underflow, e.und);
    check_eq("fifo_level", fifo_level, e.lvl);
    check_eq("wr_ready", wr_ready, e.rdy);
  endtask

  task automatic step_n(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  task automatic step_to_idx(input int target);
    for (int i = 0; i < 8 && m_idx != target; i++) step_n(1);
    check_eq("reach_idx", 64'(m_idx), 64'(target));
  endtask

  // Asynchronous reset in the low clock phase; outputs must clear without an edge.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_q_r", q_r, 6'd0);
    check_eq("rst_q_f", q_f, 6'd0);
    check_eq("rst_frame", frame, 1'b0);
    check_eq("rst_underflow", underflow, 1'b0);
    check_eq("rst_level", fifo_level, {LW{1'b0}});
    check_eq("rst_ready", wr_ready, 1'b1);
    model_reset();
    @(negedge dco);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    logic [63:0] words [6];
    for (int i = 0; i < 6; i++) words[i] = {$urandom, $urandom};

    // Reset release, word pushed at idx 3 appears in the next frame.
    mode = 2'b00;
    apply_reset();
    step_n(3);
    wr_data  = 64'h003F_0015_002A_3F00;
    wr_valid = 1'b1;
    step(acc);
    check_eq("t1_accept", 64'(acc), 64'd1);
    wr_valid = 1'b0;
    step_n(1);
    check_eq("t1_first_lo", q_f, 6'h3F);
    check_eq("t1_first_frame", frame, 1'b1);
    step_n(3);
    check_eq("t1_last_lo", q_f, 6'h00);
    step_n(1);
    check_eq("t1_last_hi", q_r, 6'h3F);

    // Clear on a non-boundary edge, then set and clear on the same edge.
    clr_underflow = 1'b1;
    step_n(1);
    clr_underflow = 1'b0;
    check_eq("t2_cleared", underflow, 1'b0);
    step_to_idx(0);
    clr_underflow = 1'b1;
    step_n(1);
    clr_underflow = 1'b0;
    check_eq("t2_set_wins", underflow, 1'b1);
    check_eq("t2_zero_frame", frame, 1'b1);
    check_eq("t2_zero_lo", q_f, 6'h00);

    // Six back-to-back words through a four-deep FIFO, no gaps, no underflow.
    mode = 2'b11;
    step_to_idx(1);
    clr_underflow = 1'b1;
    step_n(1);
    clr_underflow = 1'b0;
    mode = 2'b00;
    for (int w = 0; w < 6; w++) begin
      wr_data  = words[w];
      wr_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) step(acc);
      check_eq("t3_accepted", 64'(acc), 64'd1);
    end
    wr_valid = 1'b0;
    for (int t = 0; t < 40 && m_fifo.size() > 0; t++) step_n(1);
    mode = 2'b11;
    step_n(5);
    check_eq("t3_no_underflow", underflow, 1'b0);

    // Ramp from reset through the 12-bit wrap.
    mode = 2'b01;
    apply_reset();
    step_n(12'h0A5);
    step_n(1);
    check_eq("t4_ramp_a5_lo", q_f, 6'h25);
    step_n(1);
    check_eq("t4_ramp_a5_hi", q_r, 6'h02);
    step_n(4100 - 12'h0A7);

    // Checkerboard to FIFO at idx 2: current word finishes as checkerboard.
    mode = 2'b10;
    step_to_idx(0);
    wr_data  = 64'h1122_3344_0A0B_2C2D;
    wr_valid = 1'b1;
    step(acc);
    wr_valid = 1'b0;
    step_to_idx(2);
    mode = 2'b00;
    step_n(1);
    check_eq("t5_check_lo", q_f, 6'h15);
    step_n(1);
    check_eq("t5_check_hi", q_r, 6'h2A);
    step_n(1);
    check_eq("t5_fifo_lo", q_f, 6'h22);
    step_n(4);

    // Reset mid-word, output resumes word-aligned.
    mode = 2'b10;
    wr_data  = 64'h0102_0304_0506_0708;
    wr_valid = 1'b1;
    step(acc);
    wr_valid = 1'b0;
    step_to_idx(2);
    apply_reset();
    step_n(1);
    check_eq("t6_aligned_frame", frame, 1'b1);
    step_n(7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_playback_tx.md
Name: adc_playback_tx

Overview:
- DDR sample serializer that turns 64-bit packed words back into the 6-bit-per-edge ADC data stream.
- It is the transmit-side counterpart of the capture path. It feeds the output DDR registers and LVDS buffers that sit outside this block.
- Uses: board loopback, ADC emulation and capture-path verification.
- Includes a small input FIFO with a valid/ready handshake and built-in test patterns.

Parameters:
FIFO_DEPTH, 4, input FIFO depth in 64-bit words; power of 2, minimum 2
RAMP_W, 12, ramp counter width; fixed at 12 because 12 bits fill the two 6-bit halves

Ports:
dco  input  1  sample clock; all logic on posedge
rst_n  input  1  asynchronous active-low reset
mode  input  2  00 FIFO data, 01 ramp, 10 checkerboard, 11 zeros
wr_data  input  64  packed word: four 16-bit samples; [63:48] sent first, [15:0] sent last
wr_valid  input  1  wr_data valid
wr_ready  output  1  FIFO not full
fifo_level  output  $clog2(FIFO_DEPTH)+1  words held
q_r  output  6  data for the rising edge of the current cycle
q_f  output  6  data for the falling edge of the current cycle
frame  output  1  high in the cycle where q_f carries the low half of a word's first sample
underflow  output  1  sticky: a word boundary occurred in mode 00 while the FIFO was empty
clr_underflow  input  1  clears underflow

Behaviour:
- Clock and reset: one clock, dco. Reset is asynchronous, active-low, rst_n.
- Reset values:
  - q_r, q_f, frame, underflow: 0
  - FIFO empty; fifo_level = 0; wr_ready = 1
  - sample index idx = 0; ramp counter = 0
- Sample format: each 16-bit sample is {2'b0, hi[5:0], 2'b0, lo[5:0]}. Bits [15:14] and [7:6] are ignored.
- Edge ordering matches the capture pairing: the falling edge of cycle n carries lo_k, and the rising edge of cycle n+1 carries hi_k.
  - Each posedge: q_f <= lo of the current sample; q_r <= hi of the previous sample (held in a 6-bit register).
- Handshake:
  - A push occurs on a posedge with wr_valid && wr_ready.
  - wr_ready = (fifo_level < FIFO_DEPTH), decoded from registered state.
  - wr_data must be held until it is accepted.
- FIFO:
  - A pushed word can be popped no earlier than the next posedge; there is no fall-through.
  - A simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Serializer:
  - idx is 2 bits and increments every cycle, wrapping 3 -> 0.
  - At a posedge with idx == 0 (word boundary), the serializer latches a new 64-bit source word and the mode that applies for the next 4 samples.
  - It emits sample idx of that word: idx 0 = [63:48], idx 1 = [47:32], idx 2 = [31:16], idx 3 = [15:0].
  - frame is registered alongside q_f and is 1 exactly when q_f holds the idx-0 sample.
- Mode changes take effect only at a word boundary; mid-word changes are ignored until the next boundary.
- Mode 00 (FIFO data):
  - At the boundary, pop the FIFO head if fifo_level > 0.
  - If the FIFO is empty, emit 4 zero samples and set underflow. frame still pulses.
- Mode 01 (ramp):
  - Sample = {2'b0, r[11:6], 2'b0, r[5:0]}.
  - r increments by 1 after every emitted sample and wraps 0xFFF -> 0x000.
  - r holds its value while in other modes.
- Mode 10 (checkerboard): every sample has lo = 6'h15 and hi = 6'h2A.
- Mode 11: zeros.
- In modes 01, 10 and 11 the FIFO is not popped, but pushes continue until full.
- Latency, mode 00, starting from an empty FIFO:
  - Word accepted at edge E.
  - Popped at the first boundary at or after E+1. If idx == 0 at E+1, q_f shows lo of [63:48] after E+1, and q_r shows hi of [63:48] after E+2.
- underflow:
  - Set at the edge where it occurs; cleared by clr_underflow.
  - If set and clear happen on the same edge, set wins.
- Reset mid-word: the output and serializer state drop immediately. After release, output resumes at idx 0 with the next boundary.

Test Plan:
- Reset release, mode 00, push W = 64'h003F_0015_002A_3F00 when idx = 3 -> pushed word appears next frame.
  - q_f sequence: 3F, 15, 2A, 00. Next-cycle q_r sequence: 00, 00, 00, 3F. frame high on the first.
- Push 6 words back-to-back with FIFO_DEPTH = 4 -> wr_ready drops after 4 accepted. All 6 words are serialized in order with no gaps; underflow stays 0.
- Mode 00 with an empty FIFO for one boundary -> 4 zero samples, frame pulses, underflow = 1.
  - Asserting clr_underflow on a later non-underflow edge clears it. Set and clear on the same edge leave it at 1.
- Mode 01 from reset for 4100 samples -> ramp values 000..FFF then wrap to 000.
  - Sample 0x0A5 gives q_f = 6'h25 and next-cycle q_r = 6'h02.
- Switch mode 10 -> 00 at idx = 2 -> the current word finishes as checkerboard (q_f = 15, q_r = 2A). FIFO data starts at the next boundary.
- Assert rst_n low mid-word -> q_r, q_f, frame and underflow are 0 immediately; fifo_level = 0. The first output after release is word-aligned.
